// File: rtl/ahb_apb_pkg.sv
// Shared types and helpers for the AHB-to-APB bridge: FSM state encoding,
// AHB transfer/response codes and the APB byte-strobe generator.
package ahb_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Lane mask of 2**size bytes starting at addr_lsb; sizes above dword clamp
  // to dword and lanes shifted past byte 7 fall off the 8-bit result.
  function automatic logic [7:0] strb_gen(input logic [2:0] size, input logic [2:0] addr_lsb);
    logic [1:0] s;
    logic [3:0] nb;
    s  = (size > 3'd3) ? 2'd3 : size[1:0];
    nb = 4'd1 << s;
    return (8'hFF >> (4'd8 - nb)) << addr_lsb;
  endfunction

endpackage

// File: rtl/ahb_apb_bridge.sv
// Non-pipelined AHB slave to APB master bridge: one APB SETUP/ACCESS per
// accepted AHB transfer, with wait states, PSLVERR/timeout to two-cycle ERROR.
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                HSEL,
  input  logic [1:0]          HTRANS,
  input  logic                HWRITE,
  input  logic [2:0]          HSIZE,
  input  logic [3:0]          HPROT,
  input  logic [ADDR_W-1:0]   HADDR,
  input  logic [DATA_W-1:0]   HWDATA,
  input  logic                HREADY,
  output logic                HREADYOUT,
  output logic                HRESP,
  output logic [DATA_W-1:0]   HRDATA,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  output logic [2:0]          PPROT,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;
  localparam int unsigned CNT_W   = (TO_LAST < 2) ? 1 : $clog2(TO_LAST + 1);

  state_t              r_state;
  state_t              w_next;
  logic                w_idle_like;
  logic                w_accept;
  logic                w_timeout;
  logic [CNT_W-1:0]    r_cnt;

  logic                r_hreadyout;
  logic                r_hresp;
  logic [DATA_W-1:0]   r_hrdata;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic [STRB_W-1:0]   r_pstrb;
  logic [2:0]          r_pprot;

  logic                w_unused;
  assign w_unused = &{1'b0, HPROT[3:2]};

  always_comb begin
    w_idle_like = (r_state == ST_IDLE) || (r_state == ST_ERR2);
    w_accept    = w_idle_like && HSEL && HREADY &&
                  ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
    w_timeout   = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TO_LAST));
    w_next      = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_ERR2: w_next = w_accept ? (HWRITE ? ST_WDATA : ST_SETUP) : ST_IDLE;
      ST_WDATA:         w_next = ST_SETUP;
      ST_SETUP:         w_next = ST_ACCESS;
      // PREADY takes priority over a timeout landing in the same cycle
      ST_ACCESS: begin
        if (PREADY)         w_next = PSLVERR ? ST_ERR1 : ST_IDLE;
        else if (w_timeout) w_next = ST_ERR1;
        else                w_next = ST_ACCESS;
      end
      ST_ERR1:          w_next = ST_ERR2;
      default:          w_next = ST_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they are registered
  // and valid in the same cycle the state itself becomes visible.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= ST_IDLE;
      r_hreadyout <= 1'b1;
      r_hresp     <= HRESP_OKAY;
      r_hrdata    <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_next;
      r_hreadyout <= (w_next == ST_IDLE) || (w_next == ST_ERR2);
      r_hresp     <= ((w_next == ST_ERR1) || (w_next == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      r_psel      <= (w_next == ST_SETUP) || (w_next == ST_ACCESS);
      r_penable   <= (w_next == ST_ACCESS);

      if (w_accept) begin
        r_paddr  <= HADDR;
        r_pwrite <= HWRITE;
        r_pstrb  <= HWRITE ? STRB_W'(strb_gen(HSIZE, HADDR[2:0])) : '0;
        r_pprot  <= {~HPROT[0], 1'b1, HPROT[1]};
      end

      if (r_state == ST_WDATA) r_pwdata <= HWDATA;

      if (r_state == ST_SETUP)
        r_cnt <= '0;
      else if ((r_state == ST_ACCESS) && !PREADY)
        r_cnt <= r_cnt + CNT_W'(1);

      if ((r_state == ST_ACCESS) && PREADY && !PSLVERR && !r_pwrite)
        r_hrdata <= PRDATA;
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;
  assign HRDATA    = r_hrdata;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;

endmodule
